seven_seg_scan_ctrl: RTL and testbench

Sequencer for a 4-digit multiplexed seven-segment display built from one shared seven-segment digit decoder. It accepts a binary value through a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It holds the result in display registers and time-multiplexes the digits onto the decoder's 4-bit digit input and decimal-point flag. It drives active-low digit enables.

---
 rtl/seven_seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: double-dabble BIN->BCD loader plus 4-digit multiplexed scan for one shared 7-seg decoder.
// Latency: display registers update on the edge ending cycle BIN_W+1 after accept; load_ready high again in cycle BIN_W+2.
// Backpressure: load_ready low while converting, loads offered then are ignored. Define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_ctrl #(
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [BIN_W-1:0] load_value,
    input  logic [3:0]       dp_mask,
    output logic [3:0]       digit_code,
    output logic             digit_dp,
    output logic [3:0]       anode_n,
    output logic             busy,
    output logic             overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {READY, SHIFT, COMMIT} state_t;

    state_t           state;
    logic [BIN_W-1:0] bin_sr;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [CNT_W-1:0] shift_cnt;
    logic [3:0]       dp_pend;
    logic             ovf_pend;

    logic [3:0][3:0]  disp_dig;
    logic [3:0][3:0]  disp_dig_nxt;
    logic [3:0][3:0]  new_dig;
    logic [3:0]       disp_dp;
    logic [3:0]       disp_dp_nxt;
    logic [3:0]       new_dp;

    logic [PRE_W-1:0] presc;
    logic             presc_tc;
    logic [1:0]       scan_idx;
    logic [1:0]       idx_nxt;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Committed digit values; an out-of-range value shows as four blanks.
    always_comb begin
`ifdef SEVEN_SEG_LZB_EN
        logic lead;
        lead = 1'b1;
`endif
        new_dig = {4{4'hF}};
        new_dp  = 4'b0000;
        if (!ovf_pend) begin
            new_dig = bcd;
            new_dp  = dp_pend;
`ifdef SEVEN_SEG_LZB_EN
            for (int i = 3; i >= 1; i--) begin
                if (lead && new_dig[i] == 4'd0) begin
                    new_dig[i] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= READY;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            bin_sr     <= '0;
            bcd        <= '0;
            shift_cnt  <= '0;
            dp_pend    <= 4'b0000;
            ovf_pend   <= 1'b0;
            disp_dig   <= {4{4'hF}};
            disp_dp    <= 4'b0000;
        end else begin
            case (state)
                READY: begin
                    if (load_valid && load_ready) begin
                        bin_sr     <= load_value;
                        dp_pend    <= dp_mask;
                        bcd        <= '0;
                        shift_cnt  <= '0;
                        ovf_pend   <= 1'b0;
                        state      <= SHIFT;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Any bit carried out of the 16-bit accumulator means the value needs a fifth digit (> 9999).
                    bcd       <= {bcd_adj[14:0], bin_sr[BIN_W-1]};
                    bin_sr    <= {bin_sr[BIN_W-2:0], 1'b0};
                    ovf_pend  <= ovf_pend | bcd_adj[15];
                    shift_cnt <= shift_cnt + CNT_W'(1);
                    if (shift_cnt == CNT_W'(BIN_W - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_dig   <= new_dig;
                    disp_dp    <= new_dp;
                    overflow   <= ovf_pend;
                    state      <= READY;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= READY;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Scan outputs are fed from the next-cycle display contents so a commit is visible on the very next cycle.
    assign disp_dig_nxt = (state == COMMIT) ? new_dig : disp_dig;
    assign disp_dp_nxt  = (state == COMMIT) ? new_dp  : disp_dp;
    assign presc_tc     = (presc == PRE_W'(REFRESH_DIV - 1));
    assign idx_nxt      = presc_tc ? scan_idx + 2'd1 : scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            scan_idx   <= 2'd0;
            anode_n    <= 4'b1110;
            digit_code <= 4'hF;
            digit_dp   <= 1'b0;
        end else begin
            presc      <= presc_tc ? '0 : presc + PRE_W'(1);
            scan_idx   <= idx_nxt;
            anode_n    <= ~(4'b0001 << idx_nxt);
            digit_code <= disp_dig_nxt[idx_nxt];
            digit_dp   <= disp_dp_nxt[idx_nxt];
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed loads plus random traffic against a decimal-arithmetic reference model.
module tb_seven_seg_scan_ctrl;

    localparam int BIN_W = 14;
    localparam int RD    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_valid;
    logic             load_ready;
    logic [BIN_W-1:0] load_value;
    logic [3:0]       dp_mask;
    logic [3:0]       digit_code;
    logic             digit_dp;
    logic [3:0]       anode_n;
    logic             busy;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         e;          // rising edges since reset release
    int         phase;      // -1 idle, else cycles since accept
    int         pv;
    logic [3:0] pm;
    logic [3:0] mdig [4];
    logic [3:0] mdp;
    logic       movf;

    seven_seg_scan_ctrl #(.BIN_W(BIN_W), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .dp_mask    (dp_mask),
        .digit_code (digit_code),
        .digit_dp   (digit_dp),
        .anode_n    (anode_n),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        e     = 0;
        phase = -1;
        mdp   = 4'b0000;
        movf  = 1'b0;
        for (int i = 0; i < 4; i++) mdig[i] = 4'hF;
    endtask

    task automatic model_commit();
        int nd;
        if (pv > 9999) begin
            movf = 1'b1;
            mdp  = 4'b0000;
            for (int i = 0; i < 4; i++) mdig[i] = 4'hF;
        end else begin
            movf = 1'b0;
            mdp  = pm;
`ifdef SEVEN_SEG_LZB_EN
            nd = (pv >= 1000) ? 4 : (pv >= 100) ? 3 : (pv >= 10) ? 2 : 1;
`else
            nd = 4;
`endif
            for (int i = 0; i < 4; i++) begin
                mdig[i] = (i < nd) ? 4'((pv / (10 ** i)) % 10) : 4'hF;
            end
        end
    endtask

    task automatic model_edge();
        e++;
        if (phase < 0) begin
            if (load_valid) begin
                pv    = int'(load_value);
                pm    = dp_mask;
                phase = 1;
            end
        end else if (phase == BIN_W + 1) begin
            model_commit();
            phase = -1;
        end else begin
            phase++;
        end
    endtask

    task automatic check_all();
        int         idx;
        logic [3:0] an;
        idx     = (e / RD) % 4;
        an      = 4'hF;
        an[idx] = 1'b0;
        chk("anode_n",    anode_n,           an);
        chk("digit_code", digit_code,        mdig[idx]);
        chk("digit_dp",   {3'b000, digit_dp}, {3'b000, mdp[idx]});
        chk("load_ready", {3'b000, load_ready}, {3'b000, phase < 0});
        chk("busy",       {3'b000, busy},     {3'b000, phase >= 0});
        chk("overflow",   {3'b000, overflow}, {3'b000, movf});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic do_load(input int v, input logic [3:0] m);
        int n;
        n = 0;
        while (phase != -1 && n < 100) begin
            step();
            n++;
        end
        checks++;
        assert (n < 100) else begin
            errors++;
            $error("FAIL load_wait observed=timeout expected=ready");
        end
        load_valid = 1'b1;
        load_value = BIN_W'(v);
        dp_mask    = m;
        step();
        load_valid = 1'b0;
        repeat (BIN_W + 2 + 16) step();
    endtask

    function automatic int rand_value();
        case ($urandom % 4)
            0:       return int'($urandom_range(0, 16383));
            1:       return int'($urandom_range(9990, 10010));
            2:       return int'($urandom_range(0, 120));
            default: return ($urandom % 2) ? 16383 : 0;
        endcase
    endfunction

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        dp_mask    = 4'b0000;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();

        // Idle scan rotation
        repeat (20) step();

        do_load(1234, 4'b0000);
        do_load(10000, 4'b1111);
        do_load(9999, 4'b0101);
        do_load(7, 4'b0010);
        do_load(0, 4'b0001);
        do_load(16383, 4'b1010);

        // Second load held through the conversion is taken only once ready returns
        load_valid = 1'b1;
        load_value = BIN_W'(1111);
        dp_mask    = 4'b1000;
        step();
        load_value = BIN_W'(2222);
        dp_mask    = 4'b0100;
        repeat (BIN_W + 2) step();
        load_valid = 1'b0;
        repeat (BIN_W + 2 + 16) step();

        // Reset in the middle of converting 4321
        load_valid = 1'b1;
        load_value = BIN_W'(4321);
        dp_mask    = 4'b1111;
        step();
        load_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
        repeat (20) step();

        // Random traffic, including loads offered while busy
        for (int c = 0; c < 800; c++) begin
            load_valid = ($urandom % 3) == 0;
            load_value = BIN_W'(rand_value());
            dp_mask    = 4'($urandom_range(0, 15));
            step();
        end
        load_valid = 1'b0;
        repeat (BIN_W + 20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
